// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI command-frame controller: opcodes, FSM states, and the
// readback width.
`timescale 1ns / 1ps

package spi_frame_pkg;

    localparam logic [7:0] OP_IMAGE  = 8'h01;
    localparam logic [7:0] OP_WEIGHT = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;

    localparam int unsigned READBACK_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StOpcode,
        StImage,
        StWAddr,
        StWData,
        StRead,
        StDiscard
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Pin-level bundle between the SPI/CNN side and spi_frame_ctrl. The slave modport is the
// controller's view of the bundle, and the master modport is the driver's view.
`timescale 1ns / 1ps

interface spi_frame_ctrl_if #(
    parameter int unsigned IMG_PIXELS    = 784,
    parameter int unsigned PIX_BITS      = 1,
    parameter int unsigned DATAWIDTH_BUS = 8,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned RESULT_WIDTH  = 4
) ();

    logic                             spi_frame_ctrl_SPICLOCK;
    logic                             spi_frame_ctrl_SS_N;
    logic                             spi_frame_ctrl_MOSI;
    logic                             spi_frame_ctrl_MISO;
    logic [RESULT_WIDTH-1:0]          spi_frame_ctrl_Result_InBUS;
    logic                             spi_frame_ctrl_Result_Valid;
    logic [IMG_PIXELS*PIX_BITS-1:0]   spi_frame_ctrl_Data_OutBUS;
    logic                             spi_frame_ctrl_Data_Ready;
    logic [DATAWIDTH_BUS-1:0]         spi_frame_ctrl_Weight_OutBUS;
    logic [ADDRESS_WIDTH-1:0]         spi_frame_ctrl_Addr_OutBUS;
    logic                             spi_frame_ctrl_Weight_Valid;
    logic                             spi_frame_ctrl_Error;

    modport slave (
        input  spi_frame_ctrl_SPICLOCK,
        input  spi_frame_ctrl_SS_N,
        input  spi_frame_ctrl_MOSI,
        input  spi_frame_ctrl_Result_InBUS,
        input  spi_frame_ctrl_Result_Valid,
        output spi_frame_ctrl_MISO,
        output spi_frame_ctrl_Data_OutBUS,
        output spi_frame_ctrl_Data_Ready,
        output spi_frame_ctrl_Weight_OutBUS,
        output spi_frame_ctrl_Addr_OutBUS,
        output spi_frame_ctrl_Weight_Valid,
        output spi_frame_ctrl_Error
    );

    modport master (
        output spi_frame_ctrl_SPICLOCK,
        output spi_frame_ctrl_SS_N,
        output spi_frame_ctrl_MOSI,
        output spi_frame_ctrl_Result_InBUS,
        output spi_frame_ctrl_Result_Valid,
        input  spi_frame_ctrl_MISO,
        input  spi_frame_ctrl_Data_OutBUS,
        input  spi_frame_ctrl_Data_Ready,
        input  spi_frame_ctrl_Weight_OutBUS,
        input  spi_frame_ctrl_Addr_OutBUS,
        input  spi_frame_ctrl_Weight_Valid,
        input  spi_frame_ctrl_Error
    );

endinterface

// File: rtl/spi_frame_sync.sv
// This block brings SCLK, SS_N and MOSI into the system clock domain. It then derives
// single-cycle edge strobes from the synchronised SCLK and SS_N.
`timescale 1ns / 1ps

module spi_frame_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi_s
);

    logic [2:0] sclk_q, sclk_d;
    logic [2:0] ss_q, ss_d;
    logic [1:0] mosi_q, mosi_d;

    always_comb begin
        sclk_d = {sclk_q[1:0], sclk};
        ss_d   = {ss_q[1:0], ss_n};
        mosi_d = {mosi_q[0], mosi};
    end

    // SS_N stages reset low so that a select line already held low across reset does not
    // produce a falling edge and start a frame in the middle of the traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= sclk_d;
            ss_q   <= ss_d;
            mosi_q <= mosi_d;
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// This is an SPI mode-0 slave that decodes command frames. The frames carry image pixels,
// auto-incrementing weight bursts, or a status/prediction readback for the CNN core.
`timescale 1ns / 1ps

module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int unsigned IMG_PIXELS    = 784,
    parameter int unsigned PIX_BITS      = 1,
    parameter int unsigned DATAWIDTH_BUS = 8,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned RESULT_WIDTH  = 4
) (
    input  logic            spi_frame_ctrl_CLOCK_50,
    input  logic            spi_frame_ctrl_RESET_InLow,
    spi_frame_ctrl_if.slave bus
);

    localparam int unsigned ImgBits = IMG_PIXELS * PIX_BITS;
    localparam int unsigned ShiftW  = max_u(max_u(8, ADDRESS_WIDTH), DATAWIDTH_BUS);
    localparam int unsigned CntW    = $clog2(max_u(ImgBits, ShiftW) + 1);
    localparam int unsigned IdxW    = (ImgBits > 1) ? $clog2(ImgBits) : 1;

    logic clk, rst_n;
    assign clk   = spi_frame_ctrl_CLOCK_50;
    assign rst_n = spi_frame_ctrl_RESET_InLow;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

    spi_frame_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (bus.spi_frame_ctrl_SPICLOCK),
        .ss_n      (bus.spi_frame_ctrl_SS_N),
        .mosi      (bus.spi_frame_ctrl_MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .mosi_s    (mosi_s)
    );

    state_e                    state_q, state_d;
    logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [ShiftW-2:0]         shift_q, shift_d;
    logic [ImgBits-1:0]        data_q, data_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [DATAWIDTH_BUS-1:0]  weight_q, weight_d;
    logic                      weight_valid_q, weight_valid_d;
    logic                      data_ready_q, data_ready_d;
    logic                      error_q, error_d;
    logic                      res_flag_q, res_flag_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic [READBACK_BITS-1:0]  rd_shift_q, rd_shift_d;
    logic                      miso_q, miso_d;

    logic [ShiftW-1:0]         shift_in;
    logic [CntW-1:0]           cnt_inc;
    logic [IdxW-1:0]           img_idx;
    logic [READBACK_BITS-1:0]  readback;
    logic                      err_set, rd_clear;

    always_comb begin
        shift_in = {shift_q, mosi_s};
        cnt_inc  = bit_cnt_q + CntW'(1);
        img_idx  = IdxW'(ImgBits - 1) - bit_cnt_q[IdxW-1:0];
        readback = '0;
        readback[READBACK_BITS-1]  = error_q;
        readback[READBACK_BITS-2]  = res_flag_q;
        readback[RESULT_WIDTH-1:0] = result_q;
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        addr_d         = addr_q;
        weight_d       = weight_q;
        weight_valid_d = 1'b0;
        data_ready_d   = 1'b0;
        error_d        = error_q;
        res_flag_d     = res_flag_q;
        result_d       = result_q;
        rd_shift_d     = rd_shift_q;
        miso_d         = miso_q;
        err_set        = 1'b0;
        rd_clear       = 1'b0;

        // Each weight pulse carries the current address, and the address advances just
        // after that pulse.
        if (weight_valid_q) begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
        end

        if (ss_rise) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            unique case (state_q)
                StOpcode: err_set = (bit_cnt_q != '0);
                StImage:  err_set = 1'b1;
                StWAddr:  err_set = 1'b1;
                StWData:  err_set = (bit_cnt_q != '0);
                default:  err_set = 1'b0;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        state_d   = StOpcode;
                        bit_cnt_d = '0;
                    end
                end
                StOpcode: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[ShiftW-2:0];
                        bit_cnt_d = cnt_inc;
                        if (bit_cnt_q == CntW'(7)) begin
                            bit_cnt_d = '0;
                            case (shift_in[7:0])
                                OP_IMAGE:  state_d = StImage;
                                OP_WEIGHT: state_d = StWAddr;
                                OP_READ: begin
                                    state_d    = StRead;
                                    rd_shift_d = readback;
                                    miso_d     = readback[READBACK_BITS-1];
                                end
                                default: begin
                                    state_d = StDiscard;
                                    err_set = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                StImage: begin
                    if (sclk_rise) begin
                        data_d[img_idx] = mosi_s;
                        bit_cnt_d       = cnt_inc;
                        if (bit_cnt_q == CntW'(ImgBits - 1)) begin
                            data_ready_d = 1'b1;
                            state_d      = StDiscard;
                        end
                    end
                end
                StWAddr: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[ShiftW-2:0];
                        bit_cnt_d = cnt_inc;
                        if (bit_cnt_q == CntW'(ADDRESS_WIDTH - 1)) begin
                            addr_d    = shift_in[ADDRESS_WIDTH-1:0];
                            bit_cnt_d = '0;
                            state_d   = StWData;
                        end
                    end
                end
                StWData: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in[ShiftW-2:0];
                        bit_cnt_d = cnt_inc;
                        if (bit_cnt_q == CntW'(DATAWIDTH_BUS - 1)) begin
                            weight_d       = shift_in[DATAWIDTH_BUS-1:0];
                            weight_valid_d = 1'b1;
                            bit_cnt_d      = '0;
                        end
                    end
                end
                StRead: begin
                    if (sclk_rise) begin
                        bit_cnt_d = cnt_inc;
                        if (bit_cnt_q == CntW'(READBACK_BITS - 1)) begin
                            miso_d   = 1'b0;
                            rd_clear = 1'b1;
                            state_d  = StDiscard;
                        end
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        // The fall that trails the opcode byte must keep the MSB on MISO.
                        rd_shift_d = rd_shift_q << 1;
                        miso_d     = rd_shift_q[READBACK_BITS-2];
                    end
                end
                StDiscard: begin
                    state_d = StDiscard;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // A set of a flag takes precedence over a readback clear in the same cycle.
        if (rd_clear) begin
            error_d    = 1'b0;
            res_flag_d = 1'b0;
        end
        if (err_set) begin
            error_d = 1'b1;
        end
        if (bus.spi_frame_ctrl_Result_Valid) begin
            res_flag_d = 1'b1;
            result_d   = bus.spi_frame_ctrl_Result_InBUS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            addr_q         <= '0;
            weight_q       <= '0;
            weight_valid_q <= 1'b0;
            data_ready_q   <= 1'b0;
            error_q        <= 1'b0;
            res_flag_q     <= 1'b0;
            result_q       <= '0;
            rd_shift_q     <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            addr_q         <= addr_d;
            weight_q       <= weight_d;
            weight_valid_q <= weight_valid_d;
            data_ready_q   <= data_ready_d;
            error_q        <= error_d;
            res_flag_q     <= res_flag_d;
            result_q       <= result_d;
            rd_shift_q     <= rd_shift_d;
            miso_q         <= miso_d;
        end
    end

    assign bus.spi_frame_ctrl_MISO         = miso_q;
    assign bus.spi_frame_ctrl_Data_OutBUS  = data_q;
    assign bus.spi_frame_ctrl_Data_Ready   = data_ready_q;
    assign bus.spi_frame_ctrl_Weight_OutBUS = weight_q;
    assign bus.spi_frame_ctrl_Addr_OutBUS  = addr_q;
    assign bus.spi_frame_ctrl_Weight_Valid = weight_valid_q;
    assign bus.spi_frame_ctrl_Error        = error_q;

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Parametrised successor of the serial interface/control unit feeding the CNN core. It is an SPI mode-0 slave, oversampled in the system clock domain, that decodes command frames. It delivers:
- a configurable-depth, multi-bit-pixel image,
- auto-incrementing weight bursts,
- a readback of the prediction and status on MISO.

It sits between the chip pins and the CNN core, replacing the fixed 784x1-bit image path.

Parameters:
IMG_PIXELS, 784, pixels per image
PIX_BITS, 1, bits per pixel (1..8)
DATAWIDTH_BUS, 8, weight word width
ADDRESS_WIDTH, 16, weight address width
RESULT_WIDTH, 4, prediction width (<=6)

Ports:
spi_frame_ctrl_CLOCK_50  in  1  system clock
spi_frame_ctrl_RESET_InLow  in  1  asynchronous active-low reset
spi_frame_ctrl_SPICLOCK  in  1  SPI SCLK, async, <= CLOCK_50/4
spi_frame_ctrl_SS_N  in  1  slave select, active low
spi_frame_ctrl_MOSI  in  1  serial data in
spi_frame_ctrl_MISO  out  1  serial data out
spi_frame_ctrl_Result_InBUS  in  RESULT_WIDTH  predicted digit from CNN
spi_frame_ctrl_Result_Valid  in  1  pulse: new prediction available
spi_frame_ctrl_Data_OutBUS  out  IMG_PIXELS*PIX_BITS  image
spi_frame_ctrl_Data_Ready  out  1  1-cycle pulse: full image received
spi_frame_ctrl_Weight_OutBUS  out  DATAWIDTH_BUS  weight word
spi_frame_ctrl_Addr_OutBUS  out  ADDRESS_WIDTH  weight address
spi_frame_ctrl_Weight_Valid  out  1  1-cycle pulse: weight word valid
spi_frame_ctrl_Error  out  1  sticky frame-error flag

Behaviour:
- Reset: all outputs 0, MISO 0, FSM IDLE, error/result flags 0. Reset is asynchronous assertion only.
- SCLK, SS_N and MOSI each pass a 2-FF synchroniser plus an edge-detect FF.
- Bit sampling:
  - MOSI is sampled on a synchronised SCLK rise.
  - MISO is updated on a synchronised SCLK fall.
  - All data is MSB-first.
- Pulse timing: Data_Ready and Weight_Valid pulse exactly one cycle, in the cycle after the sampling of the completing bit.
- FSM states:
  - IDLE: on SS_N falling edge -> OPCODE. Bit counter cleared.
  - OPCODE: 8 bits, then dispatch:
    - 0x01 -> IMAGE
    - 0x02 -> W_ADDR
    - 0x03 -> READ; load readback shift register
    - other -> DISCARD; set Error
  - IMAGE: payload bit k (k=0 first) is stored at Data_OutBUS[IMG_PIXELS*PIX_BITS-1-k]. After the last bit: pulse Data_Ready, -> DISCARD. Extra bits are ignored with no error.
  - W_ADDR: ADDRESS_WIDTH bits load the address register, -> W_DATA.
  - W_DATA: each DATAWIDTH_BUS bits loads Weight_OutBUS and pulses Weight_Valid with the current Addr_OutBUS. The address increments in the cycle after the pulse, wrapping 2^ADDRESS_WIDTH-1 -> 0. The burst length is unbounded.
  - READ: the shift register holds {Error, res_flag, (6-RESULT_WIDTH) zeros, result}, 8 bits. The MSB is driven on MISO at the start of READ. After 8 bits MISO=0. Completing the 8th bit clears Error and res_flag.
  - DISCARD: ignore bits until SS_N rises.
- SS_N rise in any state -> IDLE, MISO=0. Error is set when SS_N rises:
  - in OPCODE with bits > 0;
  - in IMAGE before completion (Data_Ready not pulsed; Data_OutBUS holds partial data);
  - in W_ADDR;
  - in W_DATA with a partial word (partial word discarded, no pulse).
- SS_N rise in READ before 8 bits: no flag clearing.
- Data_OutBUS contents are valid only from Data_Ready until the next IMAGE frame starts. The consumer latches on Data_Ready.
- Result_Valid latches Result_InBUS and sets res_flag. If Result_Valid and a read-clear coincide, the set wins.
- If a frame-error set and a read-clear coincide, the set wins.
- Reset mid-frame: immediate return to IDLE, no pulses. The in-progress frame is lost; the next SS_N fall starts fresh.

Decomposition:
- Shared package spi_frame_pkg:
  - opcode constants OP_IMAGE=8'h01, OP_WEIGHT=8'h02, OP_READ=8'h03;
  - FSM state enum;
  - READBACK_BITS=8.
- One sub-module: spi_frame_sync. It holds the 3-input synchroniser plus edge detection and outputs sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s.

Test Plan:
1. SS_N low, opcode 0x01, 784 bits alternating 1,0 (PIX_BITS=1), SS_N high -> one Data_Ready pulse; Data_OutBUS[783]=1, [782]=0; Error=0.
2. Opcode 0x02, address 0xFFFE, words 0xA5, 0x3C, 0x81 -> three Weight_Valid pulses with (Addr,Weight) = (0xFFFE,0xA5), (0xFFFF,0x3C), (0x0000,0x81).
3. Opcode 0x02, address 0x0010, then 4 bits before SS_N rise -> no Weight_Valid; Error=1.
4. Result_Valid with Result_InBUS=4'd7 after test 3, then opcode 0x03 and read 8 bits -> MISO bits 1,1,0,0,0,1,1,1 (0xC7); afterwards Error=0; second read returns 0x07 with res_flag cleared, i.e. 0x07.
5. Opcode 0x5A followed by 16 bits -> no pulses, Error=1; next valid image frame completes normally.
6. RESET_InLow pulsed mid-image after 300 bits -> outputs 0, no Data_Ready; next full image frame -> Data_Ready pulse.
